// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream to instruction-memory word loader
//
// Packs an incoming byte stream into little-endian 32-bit words and writes
// them to instruction memory starting at word 0. The core pipeline is held
// in reset (core_reset = 1) from an accepted load until that load finishes.
//
// Optional build macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, the stream carries one trailing byte equal to the XOR of
//   all data bytes; a mismatch fails the load (err pulse, core stays in reset).
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous, active-high
//   load_start   one-cycle load request, sampled only in IDLE
//   load_len     number of words to load (ADDR_W+1 bits), sampled with load_start
//   in_valid     byte-stream valid
//   in_data      byte-stream data
//   in_ready     loader accepts a byte this cycle (registered, state only)
//   imem_we      instruction-memory write strobe
//   imem_addr    word address of the write
//   imem_wdata   instruction word written
//   busy         load in progress (from the cycle after an accepted start
//                until DONE is left)
//   done         one-cycle pulse on successful completion
//   err          one-cycle pulse on a rejected start or failed load
//   core_reset   reset for the pipeline stages
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              core_reset
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd3;
`endif

  // Largest legal length is exactly 2^ADDR_W words.
  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [2:0]        state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx_q;
  logic [1:0]        byte_cnt;
  logic [31:0]       word_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic accept;
  logic last_word;
  logic [31:0] word_next;

  // in_ready is a registered copy of "state is RECV/CHECK", so a byte is
  // taken exactly when the source sees ready and drives valid.
  assign accept    = in_valid && in_ready;
  // Index arithmetic is ADDR_W+1 wide so a 2^ADDR_W load ends at the last
  // address without wrapping back to 0.
  assign last_word = (idx_q == (len_q - LEN_ONE));
  // Bytes shift in from the top; after four accepts byte 0 sits in [7:0].
  assign word_next = {in_data, word_q[31:8]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      byte_cnt   <= '0;
      word_q     <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      core_reset <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      // Pulse outputs default low every cycle.
      imem_we <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;

      case (state)
        S_IDLE: begin
          if (load_start) begin
            if (load_len > LEN_MAX) begin
              // Rejected: no state change, core_reset untouched.
              err <= 1'b1;
            end else begin
              len_q    <= load_len;
              idx_q    <= '0;
              byte_cnt <= '0;
              busy     <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum_q   <= '0;
`endif
              if (load_len == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                // Empty load still carries a checksum byte (expected 0x00).
                state      <= S_CHECK;
                in_ready   <= 1'b1;
                core_reset <= 1'b1;
`else
                state      <= S_DONE;
                done       <= 1'b1;
                core_reset <= 1'b0;
`endif
              end else begin
                state      <= S_RECV;
                in_ready   <= 1'b1;
                core_reset <= 1'b1;
              end
            end
          end
        end

        S_RECV: begin
          if (accept) begin
            word_q   <= word_next;
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q   <= csum_q ^ in_data;
`endif
            if (byte_cnt == 2'd3) begin
              state      <= S_WRITE;
              in_ready   <= 1'b0;
              imem_we    <= 1'b1;
              imem_addr  <= idx_q[ADDR_W-1:0];
              imem_wdata <= word_next;
            end
          end
        end

        S_WRITE: begin
          if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state    <= S_CHECK;
            in_ready <= 1'b1;
`else
            state      <= S_DONE;
            done       <= 1'b1;
            core_reset <= 1'b0;
`endif
          end else begin
            idx_q    <= idx_q + LEN_ONE;
            state    <= S_RECV;
            in_ready <= 1'b1;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (in_data == csum_q) begin
              state      <= S_DONE;
              done       <= 1'b1;
              core_reset <= 1'b0;
            end else begin
              // Failed load: written words stay, core stays in reset.
              state <= S_IDLE;
              err   <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
`endif

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load_start = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic              core_reset;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .core_reset(core_reset)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [7:0]        src[$];
  logic [7:0]        tx_q[$];
  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];
  int rx_cnt, done_cyc, done_cnt, err_cnt, vmode;
  bit gap_phase = 1'b0;
  logic prev_we = 1'b0;
  logic st_in_ready, st_core_reset, st_busy, dn_core_reset;

  // Reference: word i of the stream is bytes 4i..4i+3, little-endian.
  function automatic logic [31:0] exp_word(int i);
    return 32'(src[4*i]) | (32'(src[4*i+1]) << 8) |
           (32'(src[4*i+2]) << 16) | (32'(src[4*i+3]) << 24);
  endfunction

  function automatic logic [7:0] xor_all();
    logic [7:0] x = 8'h00;
    foreach (src[i]) x = x ^ src[i];
    return x;
  endfunction

  // One clock: drive inputs at a negedge, observe at the next negedge.
  task automatic step();
    bit want, acc;
    case (vmode)
      0:       want = 1'b1;
      1:       want = gap_phase;
      default: want = 1'($urandom_range(0, 1));
    endcase
    gap_phase = !gap_phase;
    if (want && tx_q.size() > 0) begin
      in_valid = 1'b1; in_data = tx_q[0];
    end else begin
      in_valid = 1'b0; in_data = 8'($urandom);
    end
    acc = in_valid && in_ready && !reset;
    @(negedge clk);
    if (acc) begin void'(tx_q.pop_front()); rx_cnt++; end
    if (imem_we) begin
      checks++;
      if (prev_we) begin failures++; $display("FAIL we_back_to_back cyc=%0d got=1 exp=0", cyc); end
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
    prev_we = imem_we;
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) begin done_cyc = cyc; dn_core_reset = core_reset; end
    end
    if (err) err_cnt++;
  endtask

  task automatic clear_logs();
    wr_addr.delete(); wr_data.delete();
    rx_cnt = 0; done_cyc = -1; done_cnt = 0; err_cnt = 0;
  endtask

  task automatic make_stream(input int len);
    src.delete();
    for (int i = 0; i < 4 * len; i++) src.push_back(8'($urandom));
    tx_q = src;
    if (CSUM != 0) tx_q.push_back(xor_all());
  endtask

  task automatic do_load(input int len, input int mode, input int inject_at,
                         input int budget, output int p);
    int n;
    clear_logs();
    vmode = mode;
    load_len = (ADDR_W+1)'(len);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    load_len = (ADDR_W+1)'($urandom);
    p = cyc;
    st_in_ready = in_ready; st_core_reset = core_reset; st_busy = busy;
    n = 0;
    while (done_cyc < 0 && err_cnt == 0 && n < budget) begin
      if (n == inject_at) begin load_start = 1'b1; load_len = (ADDR_W+1)'(1); end
      step();
      load_start = 1'b0;
      n++;
    end
    checks++;
    if (n >= budget) begin failures++; $display("FAIL load_timeout len=%0d got=%0d cycles exp<%0d", len, n, budget); end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; vmode = 0;
    step(); step();
    checks += 8;
    if (in_ready   !== 1'b0)  begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    if (imem_we    !== 1'b0)  begin failures++; $display("FAIL rst_imem_we got=%b exp=0", imem_we); end
    if (imem_addr  !== '0)    begin failures++; $display("FAIL rst_imem_addr got=%0h exp=0", imem_addr); end
    if (imem_wdata !== 32'h0) begin failures++; $display("FAIL rst_imem_wdata got=%0h exp=0", imem_wdata); end
    if (busy       !== 1'b0)  begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (done       !== 1'b0)  begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    if (err        !== 1'b0)  begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
    if (core_reset !== 1'b1)  begin failures++; $display("FAIL rst_core_reset got=%b exp=1", core_reset); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_directed();
    int p;
    src = '{8'h93, 8'h02, 8'h10, 8'h00, 8'h13, 8'h03, 8'h20, 8'h00};
    tx_q = src;
    if (CSUM != 0) tx_q.push_back(xor_all());
    do_load(2, 0, -1, 60, p);
    checks += 8;
    if (st_in_ready !== 1'b1)   begin failures++; $display("FAIL dir_ready_t1 got=%b exp=1", st_in_ready); end
    if (st_core_reset !== 1'b1) begin failures++; $display("FAIL dir_core_reset_t1 got=%b exp=1", st_core_reset); end
    if (st_busy !== 1'b1)       begin failures++; $display("FAIL dir_busy_t1 got=%b exp=1", st_busy); end
    if (done_cyc !== p + 10 + CSUM) begin failures++; $display("FAIL dir_done_cycle got=%0d exp=%0d", done_cyc - p, 10 + CSUM); end
    if (dn_core_reset !== 1'b0) begin failures++; $display("FAIL dir_core_reset_at_done got=%b exp=0", dn_core_reset); end
    if (done_cnt !== 1)         begin failures++; $display("FAIL dir_done_pulses got=%0d exp=1", done_cnt); end
    if (busy !== 1'b0)          begin failures++; $display("FAIL dir_busy_after got=%b exp=0", busy); end
    if (wr_addr.size() !== 2)   begin failures++; $display("FAIL dir_write_count got=%0d exp=2", wr_addr.size()); end
    if (wr_addr.size() == 2) begin
      checks += 4;
      if (wr_addr[0] !== 4'd0) begin failures++; $display("FAIL dir_addr0 got=%0h exp=0", wr_addr[0]); end
      if (wr_data[0] !== 32'h00100293) begin failures++; $display("FAIL dir_data0 got=%h exp=00100293", wr_data[0]); end
      if (wr_addr[1] !== 4'd1) begin failures++; $display("FAIL dir_addr1 got=%0h exp=1", wr_addr[1]); end
      if (wr_data[1] !== 32'h00200313) begin failures++; $display("FAIL dir_data1 got=%h exp=00200313", wr_data[1]); end
    end
  endtask

  task automatic test_gappy();
    int p;
    make_stream(1);
    do_load(1, 1, -1, 60, p);
    checks += 3;
    if (rx_cnt !== 4 + CSUM)  begin failures++; $display("FAIL gap_bytes_consumed got=%0d exp=%0d", rx_cnt, 4 + CSUM); end
    if (tx_q.size() !== 0)    begin failures++; $display("FAIL gap_bytes_left got=%0d exp=0", tx_q.size()); end
    if (wr_addr.size() !== 1) begin failures++; $display("FAIL gap_write_count got=%0d exp=1", wr_addr.size()); end
    if (wr_addr.size() == 1) begin
      checks += 2;
      if (wr_addr[0] !== 4'd0)       begin failures++; $display("FAIL gap_addr got=%0h exp=0", wr_addr[0]); end
      if (wr_data[0] !== exp_word(0)) begin failures++; $display("FAIL gap_data got=%h exp=%h", wr_data[0], exp_word(0)); end
    end
  endtask

  task automatic test_zero_and_oversize();
    int p;
    src.delete(); tx_q.delete();
    if (CSUM != 0) tx_q.push_back(8'h00);
    do_load(0, 0, -1, 10, p);
    checks += 4;
    if (wr_addr.size() !== 0)   begin failures++; $display("FAIL zero_writes got=%0d exp=0", wr_addr.size()); end
    if (done_cyc !== p + CSUM)  begin failures++; $display("FAIL zero_done_cycle got=%0d exp=%0d", done_cyc - p, CSUM); end
    if (err_cnt !== 0)          begin failures++; $display("FAIL zero_err got=%0d exp=0", err_cnt); end
    if (core_reset !== 1'b0)    begin failures++; $display("FAIL zero_core_reset got=%b exp=0", core_reset); end
    tx_q.delete();
    do_load(DEPTH + 1, 0, -1, 10, p);
    checks += 6;
    if (err_cnt !== 1)          begin failures++; $display("FAIL big_err_pulses got=%0d exp=1", err_cnt); end
    if (st_busy !== 1'b0)       begin failures++; $display("FAIL big_busy got=%b exp=0", st_busy); end
    if (st_in_ready !== 1'b0)   begin failures++; $display("FAIL big_in_ready got=%b exp=0", st_in_ready); end
    if (st_core_reset !== 1'b0) begin failures++; $display("FAIL big_core_reset got=%b exp=0", st_core_reset); end
    if (err !== 1'b0)           begin failures++; $display("FAIL big_err_width got=%b exp=0", err); end
    if (done_cnt !== 0)         begin failures++; $display("FAIL big_done got=%0d exp=0", done_cnt); end
  endtask

  task automatic test_start_ignored();
    int p;
    make_stream(3);
    do_load(3, 0, 6, 100, p);
    checks += 2;
    if (done_cyc !== p + 15 + CSUM) begin failures++; $display("FAIL ign_done_cycle got=%0d exp=%0d", done_cyc - p, 15 + CSUM); end
    if (wr_addr.size() !== 3)       begin failures++; $display("FAIL ign_write_count got=%0d exp=3", wr_addr.size()); end
    for (int i = 0; i < wr_addr.size() && i < 3; i++) begin
      checks++;
      if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== exp_word(i)) begin
        failures++; $display("FAIL ign_word%0d got=%0h:%h exp=%0h:%h", i, wr_addr[i], wr_data[i], i, exp_word(i));
      end
    end
  endtask

  task automatic test_full_depth();
    int p;
    make_stream(DEPTH);
    do_load(DEPTH, 0, -1, 200, p);
    checks += 2;
    if (done_cyc !== p + 5 * DEPTH + CSUM) begin failures++; $display("FAIL full_done_cycle got=%0d exp=%0d", done_cyc - p, 5 * DEPTH + CSUM); end
    if (wr_addr.size() !== DEPTH) begin failures++; $display("FAIL full_write_count got=%0d exp=%0d", wr_addr.size(), DEPTH); end
    for (int i = 0; i < wr_addr.size() && i < DEPTH; i++) begin
      checks++;
      if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== exp_word(i)) begin
        failures++; $display("FAIL full_word%0d got=%0h:%h exp=%0h:%h", i, wr_addr[i], wr_data[i], i, exp_word(i));
      end
    end
  endtask

  task automatic test_reset_mid_word();
    int n, p;
    make_stream(3);
    clear_logs();
    vmode = 0;
    load_len = (ADDR_W+1)'(3); load_start = 1'b1;
    step();
    load_start = 1'b0;
    n = 0;
    while (rx_cnt < 6 && n < 50) begin step(); n++; end
    checks += 2;
    if (n >= 50) begin failures++; $display("FAIL mid_timeout got=%0d exp<50", n); end
    if (wr_addr.size() !== 1) begin failures++; $display("FAIL mid_pre_writes got=%0d exp=1", wr_addr.size()); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks += 8;
    if (in_ready   !== 1'b0)  begin failures++; $display("FAIL mid_in_ready got=%b exp=0", in_ready); end
    if (imem_we    !== 1'b0)  begin failures++; $display("FAIL mid_imem_we got=%b exp=0", imem_we); end
    if (imem_addr  !== '0)    begin failures++; $display("FAIL mid_imem_addr got=%0h exp=0", imem_addr); end
    if (imem_wdata !== 32'h0) begin failures++; $display("FAIL mid_imem_wdata got=%h exp=0", imem_wdata); end
    if (busy       !== 1'b0)  begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    if (done       !== 1'b0)  begin failures++; $display("FAIL mid_done got=%b exp=0", done); end
    if (err        !== 1'b0)  begin failures++; $display("FAIL mid_err got=%b exp=0", err); end
    if (core_reset !== 1'b1)  begin failures++; $display("FAIL mid_core_reset got=%b exp=1", core_reset); end
    for (int i = 0; i < 10; i++) step();
    checks += 2;
    if (wr_addr.size() !== 1) begin failures++; $display("FAIL mid_post_writes got=%0d exp=1", wr_addr.size()); end
    if (done_cnt !== 0)       begin failures++; $display("FAIL mid_done_seen got=%0d exp=0", done_cnt); end
    make_stream(1);
    do_load(1, 0, -1, 40, p);
    checks += 1;
    if (wr_addr.size() !== 1) begin failures++; $display("FAIL mid_fresh_count got=%0d exp=1", wr_addr.size()); end
    if (wr_addr.size() == 1) begin
      checks += 2;
      if (wr_addr[0] !== 4'd0)        begin failures++; $display("FAIL mid_fresh_addr got=%0h exp=0", wr_addr[0]); end
      if (wr_data[0] !== exp_word(0)) begin failures++; $display("FAIL mid_fresh_data got=%h exp=%h", wr_data[0], exp_word(0)); end
    end
  endtask

  task automatic test_random();
    int p, len;
    for (int k = 0; k < 5; k++) begin
      len = $urandom_range(1, 6);
      make_stream(len);
      do_load(len, 2, -1, 40 * len + 40, p);
      checks += 3;
      if (wr_addr.size() !== len) begin failures++; $display("FAIL rnd%0d_write_count got=%0d exp=%0d", k, wr_addr.size(), len); end
      if (rx_cnt !== 4 * len + CSUM) begin failures++; $display("FAIL rnd%0d_consumed got=%0d exp=%0d", k, rx_cnt, 4 * len + CSUM); end
      if (done_cnt !== 1) begin failures++; $display("FAIL rnd%0d_done got=%0d exp=1", k, done_cnt); end
      for (int i = 0; i < wr_addr.size() && i < len; i++) begin
        checks++;
        if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== exp_word(i)) begin
          failures++; $display("FAIL rnd%0d_word%0d got=%0h:%h exp=%0h:%h", k, i, wr_addr[i], wr_data[i], i, exp_word(i));
        end
      end
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int p;
    src = '{8'h93, 8'h02, 8'h10, 8'h00};
    tx_q = src; tx_q.push_back(8'h81);
    do_load(1, 0, -1, 40, p);
    checks += 2;
    if (done_cyc !== p + 6) begin failures++; $display("FAIL csum_ok_done got=%0d exp=6", done_cyc - p); end
    if (err_cnt !== 0)      begin failures++; $display("FAIL csum_ok_err got=%0d exp=0", err_cnt); end
    tx_q = src; tx_q.push_back(8'h80);
    do_load(1, 0, -1, 40, p);
    checks += 5;
    if (err_cnt !== 1)        begin failures++; $display("FAIL csum_bad_err got=%0d exp=1", err_cnt); end
    if (done_cnt !== 0)       begin failures++; $display("FAIL csum_bad_done got=%0d exp=0", done_cnt); end
    if (core_reset !== 1'b1)  begin failures++; $display("FAIL csum_bad_core_reset got=%b exp=1", core_reset); end
    if (busy !== 1'b0)        begin failures++; $display("FAIL csum_bad_busy got=%b exp=0", busy); end
    if (wr_data.size() !== 1 || wr_data[0] !== 32'h00100293) begin
      failures++; $display("FAIL csum_bad_kept_word got=%0d words exp=1 word 00100293", wr_data.size());
    end
  endtask
`endif

  initial begin
    clear_logs();
    vmode = 0;
    test_reset();
    test_directed();
    test_gappy();
    test_zero_and_oversize();
    test_start_ignored();
    test_full_depth();
    test_reset_mid_word();
    test_random();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writer side of the instruction-memory interface that instruction fetch reads. Accepts a byte stream over a valid/ready handshake and packs it into little-endian 32-bit instruction words. Writes those words sequentially into instruction memory from word 0. Holds the core pipeline in reset until a load completes.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width; capacity is 2^ADDR_W words.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `load_start`  in  1  one-cycle request to begin a load; sampled only in IDLE.
- `load_len`  in  ADDR_W+1  number of words to load; sampled with `load_start`.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream data.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  word address of the write.
- `imem_wdata`  out  32  instruction word written.
- `busy`  out  1  high from the cycle after an accepted start until DONE is left.
- `done`  out  1  one-cycle pulse when a load completes successfully.
- `err`  out  1  one-cycle pulse on a rejected start or a failed load.
- `core_reset`  out  1  drives the pipeline stages' `reset`.

## Operation
- States: IDLE, RECV, WRITE, CHECK (present only with the macro), DONE.
- IDLE:
  - `load_start` with 1 ≤ `load_len` ≤ 2^ADDR_W latches the length, clears the word index and byte counter, sets `core_reset` = 1, and goes to RECV.
  - `load_len` = 0 goes directly to DONE with no writes.
  - `load_len` > 2^ADDR_W raises `err` for one cycle and stays in IDLE; `core_reset` is unchanged.
- RECV:
  - `in_ready` = 1.
  - A byte is accepted when `in_valid && in_ready`. Byte k of the word (k = 0..3) goes to bits [8k+7:8k].
  - After the 4th byte is accepted, go to WRITE.
- WRITE (one cycle):
  - `imem_we` = 1, `imem_addr` = word index, `imem_wdata` = the assembled word.
  - If word index == len−1, go to CHECK (with macro) or DONE. Otherwise increment the index and return to RECV.
- DONE (one cycle):
  - `done` = 1, `core_reset` = 0, return to IDLE.
- `core_reset` stays 0 until the next accepted `load_start` or `reset`.
- `load_start` outside IDLE is ignored. `in_valid` outside RECV is ignored; no byte is consumed.
- Word-index arithmetic is ADDR_W+1 bits wide. `imem_addr` is its low ADDR_W bits. A length of 2^ADDR_W writes the last address, 2^ADDR_W−1, without wrap.

## Timing
- Reset values: `in_ready` 0, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `busy` 0, `done` 0, `err` 0, `core_reset` 1; state IDLE.
- `load_start` at cycle t puts the loader in RECV at t+1, with `in_ready` = 1 at t+1.
- Throughput with `in_valid` held high: 5 cycles per word (4 accept cycles, 1 write cycle).
- `done` rises the cycle after the last WRITE, or after CHECK with the macro. For N words at full rate without the macro, `done` is at t+1+5N.
- Stalls: `in_valid` low in RECV holds the state and the partial word indefinitely. There is no timeout.
- Reset at any point, including mid-word: the partial word is discarded, no further writes occur, all outputs return to reset values on the next cycle, and `core_reset` = 1.
- `imem_we` is never high for two consecutive cycles.
- Outputs are registered; `in_ready` is a function of state only.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - The stream carries one extra byte after the last word, equal to the XOR of all data bytes.
  - CHECK state asserts `in_ready` and waits for that byte.
  - On a match, go to DONE.
  - On a mismatch, pulse `err`, keep `core_reset` = 1, and return to IDLE without `done`.
  - Words already written stay in memory.
  - A `load_len` = 0 load expects a checksum byte of 0x00.
- Not defined: no CHECK state, no checksum byte, and `err` arises only from an oversize `load_len`.

## Test plan
- Reset, then `load_start` with `load_len` = 2 and bytes 93 02 10 00 13 03 20 00 at full rate -> writes 0x00100293 @0 and 0x00200313 @1, `done` at t+11, `core_reset` falls with `done`.
- `load_len` = 1 with `in_valid` toggling every other cycle -> exactly 4 bytes consumed, a single `imem_we` cycle at addr 0, no byte lost or duplicated.
- `load_len` = 0 -> no `imem_we`, `done` at t+1. `load_len` = 2^ADDR_W+1 -> `err` pulse, state stays IDLE, `busy` stays 0.
- `reset` asserted after 2 bytes of word 1 -> no further writes, all outputs at reset values the next cycle; a fresh load then starts at addr 0.
- `load_start` pulsed during RECV -> ignored; `load_len`, the index and the data path are unchanged.
- With `IMEM_LOADER_CHECKSUM_EN`, word bytes 93 02 10 00 then checksum 0x81 -> `done`. Checksum 0x80 -> `err`, no `done`, `core_reset` stays 1.
